// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder_pkg
//  Description : Shared definitions for the instruction encoder slice.
//                This package holds the immediate type codes, the FSM state
//                codes, datapath widths and a sign-extension range helper.
//                Every encoder file imports it, and none of them redefines
//                these codes locally.
//  Revision    : 1.0 - initial release
// ============================================================================
package instr_encoder_pkg;

    // Immediate type codes carried on the instr_type input
    typedef enum logic [2:0] {
        RTYPE = 3'd0,
        ITYPE = 3'd1,
        STYPE = 3'd2,
        BTYPE = 3'd3,
        UTYPE = 3'd4,
        JTYPE = 3'd5
    } imm_type_e;

    // Encoder control states; the numeric codes are visible on the state port
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } enc_state_e;

    localparam int          c_ADDR_W    = 32;
    localparam int          c_INSTR_W   = 32;
    localparam int          c_ERR_CNT_W = 8;
    localparam logic [31:0] c_ADDR_STEP = 32'd4;
    localparam logic [7:0]  c_ERR_MAX   = 8'hFF;

    // True when imm[31:msb] are all equal. In that case the value survives
    // truncation to msb+1 bits and sign extension back to 32 bits.
    function automatic logic sign_fits(input logic [31:0] imm, input int msb);
        logic all_ones;
        logic all_zeros;
        all_ones  = 1'b1;
        all_zeros = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i >= msb) begin
                all_ones  = all_ones  &  imm[i];
                all_zeros = all_zeros & ~imm[i];
            end
        end
        return all_ones | all_zeros;
    endfunction

endpackage : instr_encoder_pkg
`default_nettype wire

// File: rtl/instr_encoder_imm_pack_unit.sv
`default_nettype none
// ============================================================================
//  Module      : imm_pack_unit
//  Description : Combinational range check and field packing for one
//                instruction. The output word is the exact inverse of the
//                decoder's immediate extraction for each type. 'legal' is
//                low when the immediate cannot be represented in the chosen
//                format, or when the type code is unknown.
//  Ports       :
//    instr_type [2:0]  immediate type code (imm_type_e)
//    opcode [6:0], rd [4:0], funct3 [2:0], rs1 [4:0], rs2 [4:0],
//    funct7 [6:0]      instruction fields
//    imm [31:0]        signed immediate (a byte offset for B and J)
//    instr [31:0]      packed instruction word
//    legal             immediate is in range for the type
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_pack_unit
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  instr_type,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        legal
);

    always_comb begin
        instr = '0;
        legal = 1'b0;
        case (imm_type_e'(instr_type))
            RTYPE: begin
                instr = {funct7, rs2, rs1, funct3, rd, opcode};
                legal = 1'b1;
            end
            ITYPE: begin
                instr = {imm[11:0], rs1, funct3, rd, opcode};
                legal = sign_fits(imm, 11);
            end
            STYPE: begin
                instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal = sign_fits(imm, 11);
            end
            BTYPE: begin
                // Branch offsets are halfword aligned, so bit 0 is never
                // encoded and must be zero.
                instr = {imm[12], imm[10:5], rs2, rs1, funct3,
                         imm[4:1], imm[11], opcode};
                legal = sign_fits(imm, 12) && !imm[0];
            end
            UTYPE: begin
                // The low 12 bits cannot be encoded and must already be zero.
                instr = {imm[31:12], rd, opcode};
                legal = (imm[11:0] == 12'd0);
            end
            JTYPE: begin
                instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                legal = sign_fits(imm, 20) && !imm[0];
            end
            default: begin
                instr = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule : imm_pack_unit
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : Streams encoded instructions into a linear address space.
//                The block accepts instruction fields through a valid/ready
//                handshake, packs them with imm_pack_unit, and presents each
//                word with its write address. The write address comes from
//                a counter that starts at base_addr and steps by 4.
//                Requests whose immediate is out of range are rejected:
//                err pulses, err_cnt counts (saturating), and with
//                HALT_ON_ERR=1 the block parks in ERR until clr_err.
//  Ports       :
//    clk, rst                  rising-edge clock, synchronous active-high reset
//    start, base_addr[31:0]    enter RUN and load the word-aligned base address
//    clr_err                   leave ERR for RUN
//    in_valid / in_ready       upstream handshake
//    instr_type[2:0]           immediate type code
//    opcode, rd, funct3, rs1, rs2, funct7, imm   instruction fields
//    out_valid / out_ready     downstream handshake
//    out_instr[31:0]           encoded instruction
//    out_addr[31:0]            write address for out_instr
//    err                       one-cycle pulse per rejected request
//    err_cnt[7:0]              saturating reject count
//    state[1:0]                current FSM state (IDLE=0, RUN=1, ERR=2)
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int HALT_ON_ERR = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        clr_err,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  instr_type,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [7:0]  err_cnt,
    output logic [1:0]  state
);

    localparam logic c_HALT = (HALT_ON_ERR != 0);

    enc_state_e                 r_state;
    logic [c_ADDR_W-1:0]        r_addr;
    logic                       r_out_valid;
    logic [c_INSTR_W-1:0]       r_out_instr;
    logic [c_ADDR_W-1:0]        r_out_addr;
    logic                       r_err;
    logic [c_ERR_CNT_W-1:0]     r_err_cnt;

    logic [c_INSTR_W-1:0]       w_instr;
    logic                       w_legal;
    logic                       w_in_ready;
    logic                       w_xfer;
    logic                       w_accept;
    logic                       w_reject;

    imm_pack_unit u_pack (
        .instr_type (instr_type),
        .opcode     (opcode),
        .rd         (rd),
        .funct3     (funct3),
        .rs1        (rs1),
        .rs2        (rs2),
        .funct7     (funct7),
        .imm        (imm),
        .instr      (w_instr),
        .legal      (w_legal)
    );

    // The upstream side may hand over a request when the output register
    // is empty, or when it is being drained in this same cycle.
    assign w_in_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready);

    // start wins over a same-cycle request. The request is left
    // unaccepted so that the counter reload is not disturbed.
    assign w_xfer   = in_valid && w_in_ready && !start;
    assign w_accept = w_xfer &&  w_legal;
    assign w_reject = w_xfer && !w_legal;

    // Control: FSM, address counter and error bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_err <= w_reject;
            if (w_reject && (r_err_cnt != c_ERR_MAX)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end

            if (start) begin
                r_state <= ST_RUN;
                r_addr  <= {base_addr[31:2], 2'b00};
            end else begin
                if (w_accept) begin
                    r_addr <= r_addr + c_ADDR_STEP;
                end
                case (r_state)
                    ST_IDLE: r_state <= ST_IDLE;
                    ST_RUN: begin
                        if (w_reject && c_HALT) begin
                            r_state <= ST_ERR;
                        end
                    end
                    ST_ERR: begin
                        if (clr_err) begin
                            r_state <= ST_RUN;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Output register. A pending word is drained by out_ready in any
    // state, so entering ERR or IDLE never drops it. A new legal word
    // refills the register in the same cycle the old one leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_addr  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_instr <= w_instr;
            r_out_addr  <= r_addr;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_addr  = r_out_addr;
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;
    assign state     = r_state;

endmodule : instr_encoder
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_encoder
//  Description : Directed self-checking bench for instr_encoder. A reference
//                model computes the encodings from the instruction formats
//                using shifts and masks, and decides legality from the signed
//                value of the immediate. Every negedge, the DUT is compared
//                with the model. Hand-computed literals are also checked at
//                the key points of each scenario.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        clr_err = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  instr_type = '0;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;
    logic [7:0]  err_cnt;
    logic [1:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    instr_encoder #(.HALT_ON_ERR(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .clr_err    (clr_err),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr_type (instr_type),
        .opcode     (opcode),
        .rd         (rd),
        .funct3     (funct3),
        .rs1        (rs1),
        .rs2        (rs2),
        .funct7     (funct7),
        .imm        (imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_addr   (out_addr),
        .err        (err),
        .err_cnt    (err_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_encode(input logic [31:0] t, op, rdv, f3, r1, r2, f7, iv);
        logic [31:0] base;
        base = (rdv << 7) | op;
        case (t)
            0: return (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | base;
            1: return ((iv & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | base;
            2: return (((iv >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12)
                      | ((iv & 32'h1F) << 7) | op;
            3: return (((iv >> 12) & 32'h1) << 31) | (((iv >> 5) & 32'h3F) << 25) | (r2 << 20)
                      | (r1 << 15) | (f3 << 12) | (((iv >> 1) & 32'hF) << 8)
                      | (((iv >> 11) & 32'h1) << 7) | op;
            4: return (iv & 32'hFFFFF000) | base;
            5: return (((iv >> 20) & 32'h1) << 31) | (((iv >> 1) & 32'h3FF) << 21)
                      | (((iv >> 11) & 32'h1) << 20) | (((iv >> 12) & 32'hFF) << 12) | base;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit ref_legal(input logic [31:0] t, input logic [31:0] iv);
        int s;
        s = int'(iv);
        case (t)
            0: return 1'b1;
            1, 2: return (s >= -2048) && (s <= 2047);
            3: return (s >= -4096) && (s <= 4095) && (s % 2 == 0);
            4: return (iv % 4096) == 0;
            5: return (s >= -(1 << 20)) && (s <= (1 << 20) - 1) && (s % 2 == 0);
            default: return 1'b0;
        endcase
    endfunction

    int          m_state = 0;
    logic [31:0] m_addr = '0;
    bit          m_ov = 0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_oaddr = '0;
    bit          m_err = 0;
    int          m_cnt = 0;
    bit          model_ok = 0;

    function automatic bit m_ready();
        return (m_state == 1) && (!m_ov || out_ready);
    endfunction

    always @(posedge clk) begin
        bit xfer;
        if (rst) begin
            m_state = 0; m_addr = '0; m_ov = 0; m_instr = '0; m_oaddr = '0;
            m_err = 0; m_cnt = 0; model_ok = 1;
        end else begin
            xfer = in_valid && m_ready() && !start;
            m_err = 0;
            if (m_ov && out_ready) m_ov = 0;
            if (start) begin
                m_state = 1;
                m_addr = base_addr & 32'hFFFFFFFC;
            end else if (xfer) begin
                if (ref_legal(32'(instr_type), imm)) begin
                    m_ov = 1;
                    m_instr = ref_encode(32'(instr_type), 32'(opcode), 32'(rd), 32'(funct3),
                                         32'(rs1), 32'(rs2), 32'(funct7), imm);
                    m_oaddr = m_addr;
                    m_addr = m_addr + 32'd4;
                end else begin
                    m_err = 1;
                    if (m_cnt < 255) m_cnt++;
                    m_state = 2;
                end
            end else if (m_state == 2 && clr_err) begin
                m_state = 1;
            end
        end
    end

    // Compare process: outputs against the model on every cycle
    always @(negedge clk) begin
        if (model_ok) begin
            check("state",     32'(state),     32'(m_state));
            check("in_ready",  32'(in_ready),  32'(m_ready()));
            check("out_valid", 32'(out_valid), 32'(m_ov));
            check("err",       32'(err),       32'(m_err));
            check("err_cnt",   32'(err_cnt),   32'(m_cnt));
            check("out_instr", out_instr,      m_instr);
            check("out_addr",  out_addr,       m_oaddr);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rdv,
                           input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [6:0] f7, input logic [31:0] iv);
        instr_type = t; opcode = op; rd = rdv; funct3 = f3;
        rs1 = r1; rs2 = r2; funct7 = f7; imm = iv;
        in_valid = 1'b1;
    endtask

    task automatic do_start(input logic [31:0] ba);
        base_addr = ba;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    logic [31:0] held_instr;

    initial begin
        // Reset state
        step(); step();
        rst = 1'b0;
        check("rst_state", 32'(state), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);

        // A request in IDLE is ignored
        set_req(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
        step();
        in_valid = 1'b0;
        check("idle_no_xfer", 32'(out_valid), 32'd0);

        do_start(32'h100);
        check("start_state", 32'(state), 32'd1);

        // One request of each legal type
        set_req(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
        step(); in_valid = 1'b0;
        check("itype_instr", out_instr, 32'h00500093);
        check("itype_addr", out_addr, 32'h100);
        check("itype_valid", 32'(out_valid), 32'd1);

        set_req(3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFFFFFC);
        step(); in_valid = 1'b0;
        check("btype_instr", out_instr, 32'hFE000EE3);
        check("btype_addr", out_addr, 32'h104);

        set_req(3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h800);
        step(); in_valid = 1'b0;
        check("jtype_instr", out_instr, 32'h001000EF);

        set_req(3'd4, 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000);
        step(); in_valid = 1'b0;
        check("utype_instr", out_instr, 32'h123452B7);
        check("utype_addr", out_addr, 32'h10C);

        set_req(3'd0, 7'h33, 5'd1, 3'd0, 5'd2, 5'd3, 7'h20, 32'hDEADBEEF);
        step(); in_valid = 1'b0;
        check("rtype_instr", out_instr, 32'h403100B3);

        set_req(3'd2, 7'h23, 5'd0, 3'd2, 5'd2, 5'd5, 7'd0, 32'hFFFFFFF8);
        step(); in_valid = 1'b0;
        check("stype_instr", out_instr, 32'hFE512C23);
        check("stype_addr", out_addr, 32'h114);

        // Range error with halt
        set_req(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
        step(); in_valid = 1'b0;
        check("err_pulse", 32'(err), 32'd1);
        check("err_cnt_1", 32'(err_cnt), 32'd1);
        check("err_state", 32'(state), 32'd2);
        check("err_in_ready", 32'(in_ready), 32'd0);
        check("err_out_hold", out_instr, 32'hFE512C23);
        step();
        check("err_pulse_end", 32'(err), 32'd0);
        clr_err = 1'b1;
        step(); clr_err = 1'b0;
        check("clr_state", 32'(state), 32'd1);
        check("clr_keeps_cnt", 32'(err_cnt), 32'd1);
        set_req(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd7);
        step(); in_valid = 1'b0;
        check("addr_after_err", out_addr, 32'h118);

        // Backpressure, then back-to-back
        do_start(32'h100);
        out_ready = 1'b0;
        set_req(3'd1, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1);
        step();
        held_instr = 32'h00100113;
        for (int k = 0; k < 5; k++) begin
            imm = 32'(k + 10);
            step();
            check("bp_instr", out_instr, held_instr);
            check("bp_addr", out_addr, 32'h100);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            imm = 32'(k + 2);
            step();
            check("b2b_addr", out_addr, 32'h104 + 32'(4 * k));
            check("b2b_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        step();

        // Error count saturation with a mix of illegal requests
        for (int i = 0; i < 260; i++) begin
            case (i % 5)
                0: set_req(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
                1: set_req(3'd6, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
                2: set_req(3'd3, 7'h63, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3);
                3: set_req(3'd4, 7'h37, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h00001001);
                default: set_req(3'd5, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h00100000);
            endcase
            step();
            in_valid = 1'b0;
            clr_err = 1'b1;
            step();
            clr_err = 1'b0;
        end
        check("err_cnt_sat", 32'(err_cnt), 32'd255);

        // Address wrap, with start winning over a same-cycle request
        set_req(3'd1, 7'h13, 5'd3, 3'd0, 5'd0, 5'd0, 7'd0, 32'd4);
        base_addr = 32'hFFFFFFFF;
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_prio", 32'(out_valid), 32'd0);
        step();
        check("wrap_addr0", out_addr, 32'hFFFFFFFC);
        step(); in_valid = 1'b0;
        check("wrap_addr1", out_addr, 32'h00000000);

        // Reset in the middle of backpressure
        out_ready = 1'b0;
        set_req(3'd1, 7'h13, 5'd3, 3'd0, 5'd0, 5'd0, 7'd0, 32'd9);
        step(); in_valid = 1'b0;
        step();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_bp_valid", 32'(out_valid), 32'd0);
        check("rst_bp_state", 32'(state), 32'd0);
        check("rst_bp_cnt", 32'(err_cnt), 32'd0);
        check("rst_bp_instr", out_instr, 32'd0);
        out_ready = 1'b1;
        step(); step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_instr_encoder
`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have one clock and one reset: clk (input, 1, rising-edge clock); rst (input, 1, synchronous, active-high reset).
REQ-002 The block SHALL have parameter HALT_ON_ERR, default 1; when 1, a range error stops the block until it is cleared.
REQ-003 The block SHALL have these ports:
- start (in, 1): load base address and enter RUN.
- base_addr (in, 32): first write address; bits [1:0] are ignored.
- clr_err (in, 1): leave ERR for RUN.
- in_valid (in, 1) and in_ready (out, 1): upstream handshake.
- type (in, 3): immediate type code from Parameters.v.
- opcode (in, 7), rd (in, 5), funct3 (in, 3), rs1 (in, 5), rs2 (in, 5), funct7 (in, 7): instruction fields.
- imm (in, 32): signed immediate, as a byte offset for B and J types.
- out_valid (out, 1) and out_ready (in, 1): downstream handshake.
- out_instr (out, 32): encoded instruction.
- out_addr (out, 32): write address for out_instr.
- err (out, 1): one-cycle pulse on a rejected request.
- err_cnt (out, 8): number of rejected requests, saturating.
- state (out, 2): current FSM state.

Function
REQ-004 The FSM SHALL have three states: IDLE=0, RUN=1, ERR=2.
- IDLE to RUN on start.
- RUN to ERR on a rejected request when HALT_ON_ERR=1.
- ERR to RUN on clr_err.
- start in any state SHALL go to RUN and reload the address.
REQ-005 in_ready SHALL equal (state==RUN) && (!out_valid || out_ready).
REQ-006 A transfer SHALL occur when in_valid && in_ready; a transfer SHALL NOT occur in IDLE or ERR.
REQ-007 Range checks, with the request legal when the listed condition holds:
- ITYPE and STYPE: imm[31:11] all equal.
- BTYPE: imm[31:12] all equal and imm[0]==0.
- JTYPE: imm[31:20] all equal and imm[0]==0.
- UTYPE: imm[11:0]==0.
- RTYPE: imm is ignored.
- Any other type code: illegal.
REQ-008 Encoding SHALL be the exact inverse of the decoder's immediate extraction:
- RTYPE: {funct7, rs2, rs1, funct3, rd, opcode}.
- ITYPE: {imm[11:0], rs1, funct3, rd, opcode}.
- STYPE: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
- BTYPE: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- UTYPE: {imm[31:12], rd, opcode}.
- JTYPE: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-009 A legal transfer SHALL load out_instr and out_addr in the same cycle, so out_valid is high on the next edge (latency 1).
- out_addr SHALL take the address counter value.
- The address counter SHALL then advance by 4 and wrap modulo 2^32.
REQ-010 While out_valid && !out_ready, out_instr and out_addr SHALL hold stable.
REQ-011 out_valid SHALL clear after an out_ready handshake unless a new legal transfer happens in the same cycle; back-to-back operation SHALL sustain one instruction per cycle.
REQ-012 A rejected transfer SHALL:
- pulse err for exactly one cycle;
- increment err_cnt, saturating at 255;
- not advance the address counter;
- not change the output register.
REQ-013 When HALT_ON_ERR=0, a rejection SHALL NOT change state.
REQ-014 Entering ERR SHALL NOT drop a pending output; out_valid stays high until it is accepted.
REQ-015 start SHALL take priority over a same-cycle transfer: that transfer is not accepted and the counter loads {base_addr[31:2], 2'b00}.
REQ-016 clr_err SHALL NOT clear err_cnt.

Reset
REQ-017 On rst the block SHALL set:
- state to IDLE;
- out_valid, err, err_cnt and the address counter to 0;
- out_instr and out_addr to 0.
REQ-018 rst SHALL override every other input, including in the middle of a backpressured output.

Structure
REQ-019 Type codes (RTYPE=0, ITYPE=1, STYPE=2, BTYPE=3, UTYPE=4, JTYPE=5) and FSM state codes SHALL live in shared Parameters.v and not be redefined locally.
REQ-020 The range check and field packing SHALL be one combinational sub-module, imm_pack_unit (inputs: type and the fields; outputs: instr and legal). instr_encoder SHALL hold the FSM, address counter and output register.

Verification
REQ-021 The bench SHALL cover at least these scenarios:
- rst, start with base_addr=0x100, then ITYPE opcode=0x13 rd=1 imm=5 → out_instr=0x00500093, out_addr=0x100.
- BTYPE opcode=0x63 imm=-4 (0xFFFFFFFC) → out_instr=0xFE000EE3; JTYPE opcode=0x6F rd=1 imm=0x800 → out_instr=0x001000EF; UTYPE opcode=0x37 rd=5 imm=0x12345000 → out_instr=0x123452B7.
- ITYPE imm=2048 with HALT_ON_ERR=1 → err pulses once, err_cnt=1, state=ERR, in_ready=0, address unchanged; clr_err → state=RUN.
- out_ready held low for 5 cycles with in_valid high → out_instr and out_addr stable, in_ready=0; 3 back-to-back requests then accepted one per cycle at addresses 0x100, 0x104, 0x108.
- base_addr=0xFFFFFFFC with two requests → out_addr=0xFFFFFFFC then 0x00000000.
- rst asserted while out_valid=1 and out_ready=0 → next cycle out_valid=0, state=IDLE, err_cnt=0.
